// File: rtl/comparator_reg.sv
// Registered magnitude comparator: one-hot lt/gt/eq flags plus max/min operand,
// one cycle after a qualified sample, unsigned or two's-complement ordering.
module comparator_reg #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic             lt,
  output logic             gt,
  output logic             eq,
  output logic [WIDTH-1:0] max_out,
  output logic [WIDTH-1:0] min_out
);

  localparam int unsigned Msb = WIDTH - 1;

  logic             valid_q;
  logic             lt_q, gt_q, eq_q;
  logic [WIDTH-1:0] max_q, min_q;

  logic             lt_d, gt_d, eq_d;
  logic [WIDTH-1:0] max_d, min_d;
  logic             sign_differs;

  always_comb begin
    sign_differs = signed_mode && (a[Msb] != b[Msb]);
    eq_d         = (a == b);
    // With differing signs the negative operand (MSB set) is the smaller one;
    // otherwise an unsigned compare gives the right order in both modes.
    if (sign_differs) begin
      lt_d = a[Msb];
    end else begin
      lt_d = (a < b);
    end
    gt_d  = !lt_d && !eq_d;
    max_d = lt_d ? b : a;
    min_d = lt_d ? a : b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      max_q   <= '0;
      min_q   <= '0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        lt_q  <= lt_d;
        gt_q  <= gt_d;
        eq_q  <= eq_d;
        max_q <= max_d;
        min_q <= min_d;
      end
    end
  end

  assign out_valid = valid_q;
  assign lt        = lt_q;
  assign gt        = gt_q;
  assign eq        = eq_q;
  assign max_out   = max_q;
  assign min_out   = min_q;

endmodule

// File: tb/tb_comparator_reg.sv
// Self-checking bench for comparator_reg: integer reference model checked every
// cycle, plus directed literal checks, on a WIDTH=2 and a WIDTH=8 instance.
module tb_comparator_reg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       signed_mode;
  logic [1:0] a, b;
  logic [7:0] a8, b8;

  logic       out_valid, lt, gt, eq;
  logic [1:0] max_out, min_out;
  logic       out_valid8, lt8, gt8, eq8;
  logic [7:0] max_out8, min_out8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  comparator_reg #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .signed_mode(signed_mode),
    .a(a), .b(b), .out_valid(out_valid), .lt(lt), .gt(gt), .eq(eq),
    .max_out(max_out), .min_out(min_out)
  );

  comparator_reg #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .signed_mode(signed_mode),
    .a(a8), .b(b8), .out_valid(out_valid8), .lt(lt8), .gt(gt8), .eq(eq8),
    .max_out(max_out8), .min_out(min_out8)
  );

  // Numeric value of an operand, then its order against the other: -1, 0, +1.
  function automatic longint to_num(int w, logic [31:0] x, logic sm);
    longint v;
    v = longint'(x);
    if (sm && x[w-1]) v = v - (longint'(1) << w);
    return v;
  endfunction

  function automatic int order(int w, logic [31:0] x, logic [31:0] y, logic sm);
    longint vx, vy;
    vx = to_num(w, x, sm);
    vy = to_num(w, y, sm);
    if (vx < vy) return -1;
    if (vx > vy) return 1;
    return 0;
  endfunction

  // Reference model state.
  logic       m_valid, m_lt, m_gt, m_eq;
  logic [1:0] m_max, m_min;
  logic       m_lt8, m_gt8, m_eq8;
  logic [7:0] m_max8, m_min8;

  always @(posedge clk or negedge rst_n) begin
    int c, c8;
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_lt <= 1'b0; m_gt <= 1'b0; m_eq <= 1'b0; m_max <= '0; m_min <= '0;
      m_lt8 <= 1'b0; m_gt8 <= 1'b0; m_eq8 <= 1'b0; m_max8 <= '0; m_min8 <= '0;
    end else begin
      m_valid <= in_valid;
      if (in_valid) begin
        c  = order(2, 32'(a), 32'(b), signed_mode);
        c8 = order(8, 32'(a8), 32'(b8), signed_mode);
        m_lt <= (c < 0); m_gt <= (c > 0); m_eq <= (c == 0);
        m_max <= (c < 0) ? b : a;
        m_min <= (c < 0) ? a : b;
        m_lt8 <= (c8 < 0); m_gt8 <= (c8 > 0); m_eq8 <= (c8 == 0);
        m_max8 <= (c8 < 0) ? b8 : a8;
        m_min8 <= (c8 < 0) ? a8 : b8;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("model out_valid", 32'(out_valid), 32'(m_valid));
    chk("model flags", {29'd0, lt, gt, eq}, {29'd0, m_lt, m_gt, m_eq});
    chk("model max", 32'(max_out), 32'(m_max));
    chk("model min", 32'(min_out), 32'(m_min));
    chk("model out_valid8", 32'(out_valid8), 32'(m_valid));
    chk("model flags8", {29'd0, lt8, gt8, eq8}, {29'd0, m_lt8, m_gt8, m_eq8});
    chk("model max8", 32'(max_out8), 32'(m_max8));
    chk("model min8", 32'(min_out8), 32'(m_min8));
    if (m_valid) chk("onehot", 32'(lt + gt + eq), 32'd1);
  end

  task automatic apply(input logic [1:0] ta, input logic [1:0] tb, input logic sm,
                       input logic v);
    @(negedge clk);
    a = ta; b = tb; signed_mode = sm; in_valid = v;
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; signed_mode = 1'b0;
    a = '0; b = '0; a8 = '0; b8 = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset flags", {29'd0, lt, gt, eq}, 32'd0);
    chk("reset max/min", {max_out, min_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Before any accepted sample all flags stay 0.
    settle();
    chk("pre-sample flags", {29'd0, lt, gt, eq}, 32'd0);

    // Exhaustive WIDTH=2 unsigned, back to back.
    for (int i = 0; i < 16; i++) begin
      apply(2'(i >> 2), 2'(i & 3), 1'b0, 1'b1);
      settle();
      chk("exh out_valid", 32'(out_valid), 32'd1);
      if (i == 11) chk("2<3 lt", 32'(lt), 32'd1);
      if (i == 12) chk("3>0 gt/max/min", {gt, max_out, min_out}, {27'd0, 1'b1, 2'd3, 2'd0});
      if (i == 5)  chk("1==1 eq", 32'(eq), 32'd1);
    end

    // Signed ordering.
    apply(2'b10, 2'b01, 1'b1, 1'b1);
    settle();
    chk("signed -2<1", {lt, max_out, min_out}, {27'd0, 1'b1, 2'b01, 2'b10});
    apply(2'b10, 2'b01, 1'b0, 1'b1);
    settle();
    chk("unsigned 2>1", 32'(gt), 32'd1);

    // Hold while in_valid is low.
    apply(2'd0, 2'd3, 1'b0, 1'b1);
    settle();
    chk("hold setup lt", 32'(lt), 32'd1);
    for (int i = 0; i < 3; i++) begin
      apply(2'(i + 1), 2'(i), 1'b1, 1'b0);
      settle();
      chk("hold out_valid", 32'(out_valid), 32'd0);
      chk("hold outputs", {lt, gt, eq, max_out, min_out}, {25'd0, 3'b100, 2'd3, 2'd0});
    end

    // Equality tie-break in both modes.
    apply(2'd2, 2'd2, 1'b0, 1'b1);
    settle();
    chk("eq unsigned", {eq, max_out, min_out}, {27'd0, 1'b1, 2'd2, 2'd2});
    apply(2'd2, 2'd2, 1'b1, 1'b1);
    settle();
    chk("eq signed", {eq, max_out, min_out}, {27'd0, 1'b1, 2'd2, 2'd2});

    // WIDTH=8 extremes.
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h7F; signed_mode = 1'b1; in_valid = 1'b1;
    settle();
    chk("w8 signed -128<127", {lt8, max_out8, min_out8}, {15'd0, 1'b1, 8'h7F, 8'h80});
    @(negedge clk);
    signed_mode = 1'b0;
    settle();
    chk("w8 unsigned 128>127", 32'(gt8), 32'd1);

    // Asynchronous reset mid-stream with a transaction in flight.
    apply(2'd3, 2'd1, 1'b0, 1'b1);
    settle();
    chk("pre-reset gt", {out_valid, gt}, 32'd3);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async reset valid", 32'(out_valid), 32'd0);
    chk("async reset flags", {29'd0, lt, gt, eq}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset held", {out_valid, lt, gt, eq, max_out, min_out}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    repeat (2) settle();
    chk("post-release no result", {29'd0, out_valid, gt, eq}, 32'd0);
    apply(2'd1, 2'd2, 1'b0, 1'b1);
    settle();
    chk("post-release sample", {out_valid, lt}, 32'd3);
    apply(2'd0, 2'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
